// File: rtl/icache_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
// Default-geometry field widths live here; the top recomputes them from its own parameters.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    INVAL  = 2'd2
  } state_t;

  localparam int LINES_DEF      = 64;
  localparam int LINE_WORDS_DEF = 4;
  localparam int OB = $clog2(LINE_WORDS_DEF);
  localparam int IB = $clog2(LINES_DEF);
  localparam int TB = 30 - OB - IB;

  // Word address as {tag,index,offset}; callers unpack with widths matching their geometry.
  function automatic logic [29:0] addr_split(input logic [31:0] addr);
    return 30'(addr >> 2);
  endfunction

endpackage

// File: rtl/icache_refill.sv
// Line refill engine: issues LINE_WORDS word requests from a line base and tracks in-order responses.
// done pulses with the final response word; counters are one bit wider so LINE_WORDS itself is representable.
module icache_refill
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [31:0]                   base,
  output logic                          mem_req,
  output logic [31:0]                   mem_addr,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  output logic                          done,
  output logic                          wr_en,
  output logic [$clog2(LINE_WORDS)-1:0] wr_off
);

  localparam int OBW = $clog2(LINE_WORDS);
  localparam int CW  = OBW + 1;
  localparam logic [CW-1:0] LW_C   = CW'(LINE_WORDS);
  localparam logic [CW-1:0] LAST_C = CW'(LINE_WORDS - 1);

  logic          active_q;
  logic [CW-1:0] req_cnt_q;
  logic [CW-1:0] rsp_cnt_q;

  assign mem_req  = active_q && (req_cnt_q < LW_C);
  assign mem_addr = mem_req ? (base + 32'({req_cnt_q, 2'b00})) : 32'h0;
  assign wr_en    = active_q && mem_rvalid;
  assign wr_off   = rsp_cnt_q[OBW-1:0];
  assign done     = wr_en && (rsp_cnt_q == LAST_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else if (start) begin
      active_q  <= 1'b1;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else begin
      if (mem_req && mem_gnt) req_cnt_q <= req_cnt_q + CW'(1);
      if (wr_en)              rsp_cnt_q <= rsp_cnt_q + CW'(1);
      if (done)               active_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/icache_resp.sv
// Direct-mapped read-only instruction cache, fetch-port responder: hits answer combinationally,
// misses stall and refill one line over an in-order request/response bus.
module icache_resp
  import icache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iaddr,
  output logic [31:0] idata,
  output logic        istall,
  input  logic        inval,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int OBW = $clog2(LINE_WORDS);
  localparam int IBW = $clog2(LINES);
  localparam int TBW = 30 - OBW - IBW;

  logic           valid_q [LINES];
  logic [TBW-1:0] tag_q   [LINES];
  logic [31:0]    data_q  [LINES*LINE_WORDS];

  state_t         state_q, state_d;
  logic [IBW-1:0] sweep_q, sweep_d;
  logic           pend_q, pend_d;
  logic [31:0]    miss_q, miss_d;
  logic           start;

  logic [TBW-1:0] cur_tag;
  logic [IBW-1:0] cur_idx;
  logic [OBW-1:0] cur_off;
  logic           hit;

  logic           done;
  logic           wr_en;
  logic [OBW-1:0] wr_off;
  logic [IBW-1:0] fill_idx;
  logic [TBW-1:0] fill_tag;

  assign {cur_tag, cur_idx, cur_off} = addr_split(iaddr);
  assign fill_idx = miss_q[OBW+2 +: IBW];
  assign fill_tag = miss_q[31 -: TBW];

  assign hit    = (state_q == IDLE) && valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign istall = !hit;
  assign idata  = hit ? data_q[{cur_idx, cur_off}] : 32'h0;

  icache_refill #(
    .LINE_WORDS(LINE_WORDS)
  ) u_refill (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (miss_q),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .done      (done),
    .wr_en     (wr_en),
    .wr_off    (wr_off)
  );

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    pend_d  = pend_q;
    miss_d  = miss_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (inval) begin
          state_d = INVAL;
          sweep_d = '0;
        end else if (!hit) begin
          state_d = REFILL;
          start   = 1'b1;
          miss_d  = {cur_tag, cur_idx, {(OBW+2){1'b0}}};
        end
      end
      REFILL: begin
        // An invalidate mid-refill waits until every outstanding response has drained.
        if (inval) pend_d = 1'b1;
        if (done) begin
          state_d = (pend_q || inval) ? INVAL : IDLE;
          sweep_d = '0;
          pend_d  = 1'b0;
        end
      end
      INVAL: begin
        sweep_d = sweep_q + IBW'(1);
        if (sweep_q == IBW'(LINES - 1)) state_d = IDLE;
      end
      default: state_d = INVAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INVAL;
      sweep_q <= '0;
      pend_q  <= 1'b0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      pend_q  <= pend_d;
      miss_q  <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_en) data_q[{fill_idx, wr_off}] <= mem_rdata;
      if (done)  tag_q[fill_idx] <= fill_tag;
      if (state_q == INVAL)
        valid_q[sweep_q] <= 1'b0;
      else if (done && !(pend_q || inval))
        valid_q[fill_idx] <= 1'b1;
    end
  end

  // IF must hold the fetch address for as long as it is being stalled.
  stall_hold: assert property (@(posedge clk) disable iff (rst) istall |=> $stable(iaddr));

endmodule

// File: tb/tb_icache_resp.sv
// Directed bench for icache_resp with a latency/backpressure memory model and an address scoreboard.
module tb_icache_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        istall;
  logic        inval;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  int gnt_wait = 0;
  int rlat     = 1;
  int gnt_cnt  = 0;
  int rv_cnt   = 0;

  logic [31:0] exp_addr[$];

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;
  rsp_t pend[$];

  always #5 clk = ~clk;

  icache_resp #(
    .LINES     (64),
    .LINE_WORDS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iaddr     (iaddr),
    .idata     (idata),
    .istall    (istall),
    .inval     (inval),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: grants after gnt_wait stalled cycles, answers rlat cycles after each grant, in order.
  initial begin
    int          cyc;
    int          wait_cnt;
    bit          prev_wait;
    logic [31:0] prev_addr;
    rsp_t        r;
    cyc = 0; wait_cnt = 0; prev_wait = 0; prev_addr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        pend.delete();
        exp_addr.delete();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        wait_cnt = 0; prev_wait = 0;
      end else begin
        if (prev_wait) begin
          check("req_held", 32'(mem_req), 32'd1);
          check("addr_held", mem_addr, prev_addr);
        end
        mem_gnt = 1'b0;
        if (mem_req) begin
          if (wait_cnt >= gnt_wait) begin
            mem_gnt  = 1'b1;
            wait_cnt = 0;
            gnt_cnt++;
            if (exp_addr.size() == 0) check("req_expected", 32'(exp_addr.size()), 32'd1);
            else check("mem_addr", mem_addr, exp_addr.pop_front());
            r.due  = cyc + rlat;
            r.data = memval(mem_addr);
            pend.push_back(r);
          end else begin
            wait_cnt++;
          end
        end
        prev_wait = mem_req && !mem_gnt;
        prev_addr = mem_addr;
        mem_rvalid = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          r = pend.pop_front();
          mem_rvalid = 1'b1;
          mem_rdata  = r.data;
          rv_cnt++;
        end
      end
    end
  end

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_addr.push_back(base + 32'(4 * i));
  endtask

  task automatic set_addr(input logic [31:0] a);
    @(posedge clk); #1;
    iaddr = a;
  endtask

  task automatic fetch_hit(input logic [31:0] a);
    set_addr(a);
    @(negedge clk);
    check("hit_stall", 32'(istall), 32'd0);
    check("hit_data", idata, memval(a));
  endtask

  // Waits for the stall to drop; it must drop exactly one cycle after the last response word.
  task automatic wait_hit(input string tag, input logic [31:0] a);
    int  last_rv;
    int  hit_k;
    bit  got;
    last_rv = -10; hit_k = -1; got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (mem_rvalid) last_rv = k;
      if (!istall) begin
        got   = 1;
        hit_k = k;
      end
    end
    check({tag, "_hit_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_stall_release"}, 32'(hit_k), 32'(last_rv + 1));
      check({tag, "_idata"}, idata, memval(a));
    end
  endtask

  task automatic count_until_req(output int n);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (mem_req) break;
      n++;
    end
  endtask

  task automatic refill(input logic [31:0] a);
    int g0;
    g0 = gnt_cnt;
    set_addr(a);
    push_line(a);
    @(negedge clk);
    check("miss_stall", 32'(istall), 32'd1);
    check("miss_idata_zero", idata, 32'h0);
    wait_hit("refill", a);
    check("req_count", 32'(gnt_cnt - g0), 32'd4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int g0;
    int r0;
    bit seen;
    rst = 1'b1; iaddr = 32'h100; inval = 1'b0;

    // Reset state and power-up sweep
    @(negedge clk);
    check("rst_stall", 32'(istall), 32'd1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_idata", idata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_line(32'h100);
    count_until_req(n);
    check("sweep_then_req", 32'(n), 32'd65);
    wait_hit("first", 32'h100);
    fetch_hit(32'h104);
    fetch_hit(32'h108);
    fetch_hit(32'h10C);

    // Conflict miss on the same index with a different tag
    refill(32'h500);
    refill(32'h100);

    // Slow grants and long response latency
    gnt_wait = 3; rlat = 5;
    refill(32'h2000);
    repeat (3) @(negedge clk);
    check("bp_req_idle", 32'(mem_req), 32'd0);
    gnt_wait = 0; rlat = 1;

    // Invalidate arriving mid-refill after the first response
    g0 = gnt_cnt; r0 = rv_cnt;
    set_addr(32'h3000);
    push_line(32'h3000);
    push_line(32'h3000);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (mem_rvalid) seen = 1;
    end
    check("inv_first_rsp", 32'(seen), 32'd1);
    @(posedge clk); #1 inval = 1'b1;
    @(posedge clk); #1 inval = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (rv_cnt >= r0 + 4) seen = 1;
    end
    check("inv_rsp_drained", 32'(seen), 32'd1);
    check("inv_grants", 32'(gnt_cnt - g0), 32'd4);
    check("inv_stall", 32'(istall), 32'd1);
    count_until_req(n);
    check("inv_sweep_then_req", 32'(n), 32'd65);
    wait_hit("inv_rerefill", 32'h3000);

    // Invalidate and miss in the same idle cycle
    @(posedge clk); #1;
    iaddr = 32'h4000; inval = 1'b1;
    push_line(32'h4000);
    @(posedge clk); #1 inval = 1'b0;
    count_until_req(n);
    check("inval_wins_over_miss", 32'(n), 32'd65);
    wait_hit("after_inval", 32'h4000);
    refill(32'h100);

    // Reset in the middle of a refill
    g0 = gnt_cnt;
    set_addr(32'h5000);
    push_line(32'h5000);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (gnt_cnt >= g0 + 2) seen = 1;
    end
    check("mid_grants", 32'(seen), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_addr", mem_addr, 32'h0);
    check("mid_rst_stall", 32'(istall), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    push_line(32'h5000);
    count_until_req(n);
    check("mid_rst_sweep", 32'(n), 32'd65);
    wait_hit("mid_rst_refill", 32'h5000);
    refill(32'h100);
    fetch_hit(32'h10C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
